// File: rtl/bch_phase_sch.sv
// bch_phase_sch: sequences one BCH codeword through SYN -> KES -> CHS.
// Optional BCH_PHASE_SCH_ZERO_SKIP_EN: all-zero syndromes skip KES/CHS.
module bch_phase_sch #(
  parameter int SYN_CYCLE   = 255,
  parameter int KES_CYCLE   = 16,
  parameter int CHS_CYCLE   = 255,
  parameter int PARALLELISM = 1,
  localparam int SYN_LEN =
    (SYN_CYCLE + PARALLELISM - 1) / PARALLELISM,
  localparam int CHS_LEN =
    (CHS_CYCLE + PARALLELISM - 1) / PARALLELISM,
  localparam int KES_LEN = KES_CYCLE,
  localparam int MAX_SK =
    (SYN_LEN > KES_LEN) ? SYN_LEN : KES_LEN,
  localparam int MAX_LEN =
    (MAX_SK > CHS_LEN) ? MAX_SK : CHS_LEN,
  localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             in_Arst_n,
  input  logic             in_Srst,
  input  logic             in_start,
  input  logic             in_hold,
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
  input  logic             in_syn_zero,
`endif
  output logic             out_ready,
  output logic             out_busy,
  output logic [1:0]       out_phase,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_syn_init,
  output logic             out_syn_en,
  output logic             out_kes_init,
  output logic             out_kes_en,
  output logic             out_chs_init,
  output logic             out_chs_en,
  output logic             out_done,
  output logic             out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYN  = 2'd1,
    S_KES  = 2'd2,
    S_CHS  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYN_L = CNT_W'(SYN_LEN);
  localparam logic [CNT_W-1:0] KES_L = CNT_W'(KES_LEN);
  localparam logic [CNT_W-1:0] CHS_L = CNT_W'(CHS_LEN);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done;
  logic             err;

  // Phase FSM: counter runs 1..LEN per phase, hold freezes it.
  always_ff @(posedge clk or negedge in_Arst_n) begin
    if (!in_Arst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (in_Srst) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_start && (state != S_IDLE))
        err <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (in_start) begin
            state <= S_SYN;
            cnt   <= ONE;
          end
        end
        S_SYN: begin
          if (!in_hold) begin
            if (cnt == SYN_L) begin
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
              if (in_syn_zero) begin
                state <= S_IDLE;
                cnt   <= '0;
                done  <= 1'b1;
              end else begin
                state <= S_KES;
                cnt   <= ONE;
              end
`else
              state <= S_KES;
              cnt   <= ONE;
`endif
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_KES: begin
          if (!in_hold) begin
            if (cnt == KES_L) begin
              state <= S_CHS;
              cnt   <= ONE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_CHS: begin
          if (!in_hold) begin
            if (cnt == CHS_L) begin
              state <= S_IDLE;
              cnt   <= '0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
      endcase
    end
  end

  assign out_ready = (state == S_IDLE);
  assign out_busy  = (state != S_IDLE);
  assign out_phase = state;
  assign out_cnt   = cnt;
  assign out_done  = done;
  assign out_err   = err;

  assign out_syn_en = (state == S_SYN) && !in_hold;
  assign out_kes_en = (state == S_KES) && !in_hold;
  assign out_chs_en = (state == S_CHS) && !in_hold;

  assign out_syn_init = out_syn_en && (cnt == ONE);
  assign out_kes_init = out_kes_en && (cnt == ONE);
  assign out_chs_init = out_chs_en && (cnt == ONE);

endmodule

// File: tb/tb_bch_phase_sch.sv
// tb_bch_phase_sch: scoreboard bench for the BCH phase scheduler.
// Main DUT uses lengths 8/4/8; a second instance uses PARALLELISM=3.
module tb_bch_phase_sch;

  localparam int SYN_LEN = 8;
  localparam int KES_LEN = 4;
  localparam int CHS_LEN = 8;
  localparam int TOTAL   = SYN_LEN + KES_LEN + CHS_LEN;

  typedef struct packed {
    logic       dn;
    logic [1:0] ph;
    logic [3:0] cn;
  } rec_t;

  logic clk;
  logic arst_n;
  logic srst;
  logic start;
  logic hold;
  logic start3;
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
  logic szero;
  logic szero3;
`endif

  logic       ready, busy, done, err;
  logic [1:0] phase;
  logic [3:0] cnt;
  logic       syn_init, syn_en, kes_init, kes_en;
  logic       chs_init, chs_en;

  logic       ready3, busy3, done3, err3;
  logic [1:0] phase3;
  logic [2:0] cnt3;
  logic       syn_init3, syn_en3, kes_init3, kes_en3;
  logic       chs_init3, chs_en3;

  int   n_vec = 0;
  int   n_err = 0;

  int   m_left = 0;
  logic m_err  = 1'b0;
  logic m_done = 1'b0;
  rec_t sbq[$];

  int   p_en, p_kes, p_chs_init, p_done_cnt, p_done_at;
  int   p_syn[$];

  bch_phase_sch #(
    .SYN_CYCLE(8), .KES_CYCLE(4),
    .CHS_CYCLE(8), .PARALLELISM(1)
  ) u_dut (
    .clk(clk), .in_Arst_n(arst_n), .in_Srst(srst),
    .in_start(start), .in_hold(hold),
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
    .in_syn_zero(szero),
`endif
    .out_ready(ready), .out_busy(busy),
    .out_phase(phase), .out_cnt(cnt),
    .out_syn_init(syn_init), .out_syn_en(syn_en),
    .out_kes_init(kes_init), .out_kes_en(kes_en),
    .out_chs_init(chs_init), .out_chs_en(chs_en),
    .out_done(done), .out_err(err)
  );

  bch_phase_sch #(
    .SYN_CYCLE(8), .KES_CYCLE(4),
    .CHS_CYCLE(8), .PARALLELISM(3)
  ) u_p3 (
    .clk(clk), .in_Arst_n(arst_n), .in_Srst(srst),
    .in_start(start3), .in_hold(hold),
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
    .in_syn_zero(szero3),
`endif
    .out_ready(ready3), .out_busy(busy3),
    .out_phase(phase3), .out_cnt(cnt3),
    .out_syn_init(syn_init3), .out_syn_en(syn_en3),
    .out_kes_init(kes_init3), .out_kes_en(kes_en3),
    .out_chs_init(chs_init3), .out_chs_en(chs_en3),
    .out_done(done3), .out_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic d,
                              input int p, input int c);
    rec_t r;
    r.dn = d;
    r.ph = 2'(p);
    r.cn = 4'(c);
    return r;
  endfunction

  function automatic int cur();
    return TOTAL - m_left + 1;
  endfunction

  task automatic push_cw();
    for (int s = 1; s <= SYN_LEN; s++) sbq.push_back(mk(0, 1, s));
    for (int s = 1; s <= KES_LEN; s++) sbq.push_back(mk(0, 2, s));
    for (int s = 1; s <= CHS_LEN; s++) sbq.push_back(mk(0, 3, s));
    sbq.push_back(mk(1, 0, 0));
  endtask

  task automatic model_clear();
    m_left = 0;
    m_err  = 1'b0;
    m_done = 1'b0;
    sbq.delete();
  endtask

  // One clock: drive inputs, then advance the reference model.
  task automatic step(input logic st, input logic hd,
                      input logic sr);
    start = st;
    hold  = hd;
    srst  = sr;
    @(posedge clk);
    if (!arst_n || sr) begin
      model_clear();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (st) m_err = 1'b1;
        if (!hd) begin
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
          if (cur() == SYN_LEN && szero) begin
            m_left = 1;
            while (sbq.size() > 0 && !sbq[0].dn)
              void'(sbq.pop_front());
          end
`endif
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end
      end else if (st) begin
        m_left = TOTAL;
        push_cw();
      end
    end
    #1;
  endtask

  task automatic adv_to(input int tgt);
    for (int k = 0; k < 60 && !(m_left > 0 && cur() == tgt); k++)
      step(0, 0, 0);
    check("reach_step", int'(m_left > 0 && cur() == tgt), 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !m_done; k++)
      step(0, 0, 0);
    check("reach_done", int'(m_done), 1);
  endtask

  // Monitor: per-cycle status plus scoreboard pops on enable/done.
  always @(negedge clk) begin
    rec_t r;
    logic bm;
    bm = (m_left != 0);
    check("ready", int'(ready), int'(!bm));
    check("busy", int'(busy), int'(bm));
    check("err", int'(err), int'(m_err));
    check("done", int'(done), int'(m_done));
    check("any_en", int'(syn_en | kes_en | chs_en),
          int'(bm && !hold));
    if (bm) begin
      if (sbq.size() == 0) begin
        check("sb_peek_empty", 0, 1);
      end else begin
        r = sbq[0];
        check("phase", int'(phase), int'(r.ph));
        check("cnt", int'(cnt), int'(r.cn));
      end
    end else begin
      check("idle_phase", int'(phase), 0);
      check("idle_cnt", int'(cnt), 0);
    end
    if (syn_en | kes_en | chs_en) begin
      if (sbq.size() == 0) begin
        check("sb_en_empty", 0, 1);
      end else begin
        r = sbq.pop_front();
        check("rec_kind", int'(r.dn), 0);
        check("syn_en", int'(syn_en), int'(r.ph == 2'd1));
        check("kes_en", int'(kes_en), int'(r.ph == 2'd2));
        check("chs_en", int'(chs_en), int'(r.ph == 2'd3));
        check("syn_init", int'(syn_init),
              int'(r.ph == 2'd1 && r.cn == 4'd1));
        check("kes_init", int'(kes_init),
              int'(r.ph == 2'd2 && r.cn == 4'd1));
        check("chs_init", int'(chs_init),
              int'(r.ph == 2'd3 && r.cn == 4'd1));
      end
    end else begin
      check("init_idle",
            int'(syn_init | kes_init | chs_init), 0);
    end
    if (done) begin
      if (sbq.size() == 0) begin
        check("sb_done_empty", 0, 1);
      end else begin
        r = sbq.pop_front();
        check("done_rec", int'(r.dn), 1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0;
    start  = 1'b0;
    hold   = 1'b0;
    srst   = 1'b0;
    start3 = 1'b0;
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
    szero  = 1'b0;
    szero3 = 1'b0;
`endif
    repeat (3) step(0, 0, 0);
    arst_n = 1'b1;
    step(0, 0, 0);

    // single codeword, no hold
    step(1, 0, 0);
    repeat (24) step(0, 0, 0);

    // hold two cycles at KES cnt=2
    step(1, 0, 0);
    adv_to(SYN_LEN + 2);
    step(0, 1, 0);
    step(0, 1, 0);
    wait_done();
    step(0, 0, 0);

    // start while busy, then back-to-back start on done
    step(1, 0, 0);
    adv_to(5);
    step(1, 0, 0);
    wait_done();
    step(1, 0, 0);

    // async reset in CHS cnt=4
    adv_to(SYN_LEN + KES_LEN + 4);
    arst_n = 1'b0;
    #1;
    model_clear();
    step(0, 0, 0);
    step(0, 0, 0);
    arst_n = 1'b1;
    step(0, 0, 0);
    step(1, 0, 0);
    wait_done();
    step(0, 0, 0);

    // sync clear in CHS cnt=4, then start masked by clear
    step(1, 0, 0);
    adv_to(5);
    step(1, 0, 0);
    adv_to(SYN_LEN + KES_LEN + 4);
    step(0, 0, 1);
    step(1, 0, 1);
    repeat (2) step(0, 0, 0);

    // PARALLELISM=3 instance
    p_en = 0;
    p_kes = 0;
    p_chs_init = 0;
    p_done_cnt = 0;
    p_done_at = 0;
    start3 = 1'b1;
    step(0, 0, 0);
    start3 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (syn_en3 | kes_en3 | chs_en3) p_en++;
      if (syn_en3) p_syn.push_back(int'(cnt3));
      if (kes_en3) p_kes++;
      if (chs_init3) p_chs_init++;
      if (done3) begin
        p_done_cnt++;
        p_done_at = i;
      end
      step(0, 0, 0);
    end
    check("p3_en_total", p_en, 10);
    check("p3_syn_len", p_syn.size(), 3);
    for (int k = 0; k < p_syn.size(); k++)
      check("p3_syn_cnt", p_syn[k], k + 1);
    check("p3_kes_len", p_kes, 4);
    check("p3_chs_init", p_chs_init, 1);
    check("p3_done_cnt", p_done_cnt, 1);
    check("p3_done_at", p_done_at, 11);
    check("p3_ready", int'(ready3), 1);
    check("p3_err", int'(err3), 0);

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
      szero = 1'($urandom_range(0, 1));
`endif
      step(1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 149) == 0));
    end
`ifdef BCH_PHASE_SCH_ZERO_SKIP_EN
    szero = 1'b0;
`endif
    repeat (40) step(0, 0, 0);
    check("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
